hsid_sq_df_acc: RTL and testbench

Squared-difference accumulator that feeds `hsid_divider`. It streams one band pair per cycle: a captured pixel band and the matching library reference band. It computes the sum of squared band differences and counts the bands. It then presents the (sum, band count, overflow, library reference) tuple as dividend, divisor, `of_in` and `hsp_ref_in` for the divider's MSE computation. A valid/ready handshake on the output holds the result until the divider accepts it.

---
 rtl/hsid_pkg.sv | 25 ++
 rtl/hsid_sq_df.sv | 49 ++++
 rtl/hsid_sq_df_acc_sva.sv | 53 +++++
 rtl/hsid_sq_df_acc.sv | 144 ++++++++++++++
 tb/tb_hsid_sq_df_acc.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hsid_pkg.sv
// -----------------------------------------------------------------------------
// hsid_pkg
// Shared types and constants for the HSID datapath blocks.
//   HSID_HSP_LIBRARY_WIDTH : default width of a library reference index
//   hsid_ite_div_state_t   : iterative divider FSM states
//   hsid_sq_df_acc_state_t : squared-difference accumulator FSM states
// -----------------------------------------------------------------------------
package hsid_pkg;

    localparam int HSID_HSP_LIBRARY_WIDTH = 8;

    typedef enum logic [1:0] {
        HID_IDLE,
        HID_RUN,
        HID_DONE
    } hsid_ite_div_state_t;

    typedef enum logic [1:0] {
        HSA_IDLE,
        HSA_ACC,
        HSA_DRAIN,
        HSA_OUT
    } hsid_sq_df_acc_state_t;

endpackage

// File: rtl/hsid_sq_df.sv
// -----------------------------------------------------------------------------
// hsid_sq_df
// Registered absolute difference of two unsigned samples, followed by a
// combinational square of the registered difference.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous flush of the stage valid
//   i_vld      : operand pair present this cycle
//   i_a, i_b   : unsigned operands
//   o_vld      : registered stage valid
//   o_sq       : |a-b|^2 of the registered pair, 2*WORD_WIDTH bits
// -----------------------------------------------------------------------------
module hsid_sq_df #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_vld,
    input  logic [WORD_WIDTH-1:0]   i_a,
    input  logic [WORD_WIDTH-1:0]   i_b,
    output logic                    o_vld,
    output logic [2*WORD_WIDTH-1:0] o_sq
);

    logic                  r_vld;
    logic [WORD_WIDTH-1:0] r_diff;
    logic [WORD_WIDTH-1:0] w_diff;

    // Subtract larger minus smaller so the result never wraps.
    assign w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_diff <= '0;
        end else if (i_clear) begin
            r_vld  <= 1'b0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_diff <= w_diff;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_sq  = (2*WORD_WIDTH)'(r_diff) * (2*WORD_WIDTH)'(r_diff);

endmodule

// File: rtl/hsid_sq_df_acc_sva.sv
// -----------------------------------------------------------------------------
// hsid_sq_df_acc_sva
// Protocol and saturation properties of hsid_sq_df_acc, bound to every
// instance of the accumulator.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous flush
//   band_ready            : input-side ready
//   acc_valid, acc_ready  : output handshake
//   acc_value, band_count : result being held
//   acc_of                : sticky overflow
// -----------------------------------------------------------------------------
module hsid_sq_df_acc_sva #(
    parameter int K = 32
) (
    input logic           clk,
    input logic           rst_n,
    input logic           clear,
    input logic           band_ready,
    input logic           acc_valid,
    input logic           acc_ready,
    input logic [2*K-1:0] acc_value,
    input logic [K-1:0]   band_count,
    input logic           acc_of
);

    a_clear_blocks_input: assert property (@(posedge clk) disable iff (!rst_n)
        clear |-> !band_ready);

    a_no_input_while_out: assert property (@(posedge clk) disable iff (!rst_n)
        acc_valid |-> !band_ready);

    a_hold_until_taken: assert property (@(posedge clk) disable iff (!rst_n)
        (acc_valid && !acc_ready && !clear) |=>
        (acc_valid && $stable(acc_value) && $stable(band_count) && $stable(acc_of)));

    // Overflow comes either from the count (which then sits at all ones) or
    // from the sum (which then sits at all ones).
    a_of_saturates: assert property (@(posedge clk) disable iff (!rst_n)
        (acc_of && (band_count != '1)) |-> (acc_value == '1));

endmodule

bind hsid_sq_df_acc hsid_sq_df_acc_sva #(.K(K)) u_sva (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .band_ready (band_ready),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_value  (acc_value),
    .band_count (band_count),
    .acc_of     (acc_of)
);

// File: rtl/hsid_sq_df_acc.sv
// -----------------------------------------------------------------------------
// hsid_sq_df_acc
// Streams one (captured, reference) band pair per cycle, accumulates the sum
// of squared band differences and the band count, and offers the result to
// the divider through a valid/ready handshake.
//   clk, rst_n       : clock, asynchronous active-low reset
//   clear            : synchronous flush, highest priority
//   band_valid/ready : band pair handshake; band_last marks the pixel end
//   vctp, vref       : captured and library band samples, unsigned
//   hsp_ref_in       : library index, sampled with the first band only
//   acc_valid/ready  : result handshake
//   acc_value        : saturating sum of squared differences (DK bits)
//   band_count       : bands accepted (K bits, saturating)
//   acc_of           : sticky sum or count overflow
//   hsp_ref_out      : library index of the pixel being reported
// -----------------------------------------------------------------------------
module hsid_sq_df_acc
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH        = 16,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter int K                 = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         band_valid,
    output logic                         band_ready,
    input  logic                         band_last,
    input  logic [WORD_WIDTH-1:0]        vctp,
    input  logic [WORD_WIDTH-1:0]        vref,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_in,
    output logic                         acc_valid,
    input  logic                         acc_ready,
    output logic [2*K-1:0]               acc_value,
    output logic [K-1:0]                 band_count,
    output logic                         acc_of,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_out
);

    localparam int DK = 2*K;

    hsid_sq_df_acc_state_t          r_state;
    logic [DK-1:0]                  r_acc;
    logic [K-1:0]                   r_cnt;
    logic                           r_of;
    logic                           r_acc_valid;
    logic [HSP_LIBRARY_WIDTH-1:0]   r_ref;

    logic                           w_band_acc;
    logic                           w_s1_vld;
    logic [2*WORD_WIDTH-1:0]        w_sq;
    logic [DK:0]                    w_sum;

    // Only decoded output: accept while collecting bands, never during clear.
    assign band_ready = !clear && ((r_state == HSA_IDLE) || (r_state == HSA_ACC));
    assign w_band_acc = band_valid && band_ready;

    hsid_sq_df #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_sq_df (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_vld   (w_band_acc),
        .i_a     (vctp),
        .i_b     (vref),
        .o_vld   (w_s1_vld),
        .o_sq    (w_sq)
    );

    // One extra bit catches the carry out of the DK-bit add.
    assign w_sum = {1'b0, r_acc} + (DK+1)'(w_sq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HSA_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_of        <= 1'b0;
            r_acc_valid <= 1'b0;
            r_ref       <= '0;
        end else if (clear) begin
            r_state     <= HSA_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_of        <= 1'b0;
            r_acc_valid <= 1'b0;
            r_ref       <= '0;
        end else begin
            // Stage 2: only ever valid in ACC or DRAIN, so it never races
            // the zeroing done on the OUT handshake below.
            if (w_s1_vld) begin
                if (w_sum[DK]) begin
                    r_acc <= '1;
                    r_of  <= 1'b1;
                end else begin
                    r_acc <= w_sum[DK-1:0];
                end
                if (&r_cnt) begin
                    r_of <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + K'(1);
                end
            end

            case (r_state)
                HSA_IDLE: begin
                    if (w_band_acc) begin
                        r_ref   <= hsp_ref_in;
                        r_state <= band_last ? HSA_DRAIN : HSA_ACC;
                    end
                end
                HSA_ACC: begin
                    if (w_band_acc && band_last) begin
                        r_state <= HSA_DRAIN;
                    end
                end
                HSA_DRAIN: begin
                    // The last square lands in the accumulator this cycle.
                    r_state     <= HSA_OUT;
                    r_acc_valid <= 1'b1;
                end
                HSA_OUT: begin
                    if (acc_ready) begin
                        r_state     <= HSA_IDLE;
                        r_acc_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_of        <= 1'b0;
                    end
                end
                default: r_state <= HSA_IDLE;
            endcase
        end
    end

    assign acc_valid   = r_acc_valid;
    assign acc_value   = r_acc;
    assign band_count  = r_cnt;
    assign acc_of      = r_of;
    assign hsp_ref_out = r_ref;

endmodule

// File: tb/tb_hsid_sq_df_acc.sv
module tb_hsid_sq_df_acc;

    // Two instances share all inputs: the default K=32 and a narrow K=16 that
    // exercises sum saturation.
    logic        clk, rst_n, clear, band_valid, band_last, acc_ready;
    logic [15:0] vctp, vref;
    logic [7:0]  hsp_ref_in;

    logic        band_ready_a, acc_valid_a, acc_of_a;
    logic [63:0] acc_value_a;
    logic [31:0] band_count_a;
    logic [7:0]  hsp_ref_out_a;

    logic        band_ready_b, acc_valid_b, acc_of_b;
    logic [31:0] acc_value_b;
    logic [15:0] band_count_b;
    logic [7:0]  hsp_ref_out_b;

    hsid_sq_df_acc #(.WORD_WIDTH(16), .HSP_LIBRARY_WIDTH(8), .K(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .band_valid(band_valid),
        .band_ready(band_ready_a), .band_last(band_last), .vctp(vctp), .vref(vref),
        .hsp_ref_in(hsp_ref_in), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
        .acc_value(acc_value_a), .band_count(band_count_a), .acc_of(acc_of_a),
        .hsp_ref_out(hsp_ref_out_a));

    hsid_sq_df_acc #(.WORD_WIDTH(16), .HSP_LIBRARY_WIDTH(8), .K(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .band_valid(band_valid),
        .band_ready(band_ready_b), .band_last(band_last), .vctp(vctp), .vref(vref),
        .hsp_ref_in(hsp_ref_in), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
        .acc_value(acc_value_b), .band_count(band_count_b), .acc_of(acc_of_b),
        .hsp_ref_out(hsp_ref_out_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Bands of the pixel being sent.
    logic [15:0] q_c[8];
    logic [15:0] q_r[8];
    logic [7:0]  q_h[8];

    // Reference: sum over bands of (captured - reference)^2 in plain integers,
    // then clipped to the output width.
    function automatic longint unsigned model_sum(input int nb);
        longint unsigned s = 0;
        for (int i = 0; i < nb; i++) begin
            longint d = longint'(q_c[i]) - longint'(q_r[i]);
            s += longint'(d * d);
        end
        return s;
    endfunction

    // Sends nb bands (with random gaps up to gap_max), checks the 2-cycle
    // latency and results, holds acc_ready low wait_cyc cycles with junk bands
    // driven, then hands the result off and checks the return to idle.
    task automatic run_pixel(input int nb, input int gap_max, input int wait_cyc,
                             input logic [63:0] e32, input logic [31:0] e16,
                             input logic eof16);
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            band_valid = 1'b1; vctp = q_c[i]; vref = q_r[i];
            hsp_ref_in = q_h[i]; band_last = (i == nb-1);
            @(negedge clk);
            chk("band_ready_collect", {63'd0, band_ready_a}, 64'd1);
            @(posedge clk); #1;
            if (i != nb-1) begin
                int g = $urandom_range(0, gap_max);
                repeat (g) begin
                    band_valid = 1'b0; vctp = 16'($urandom); band_last = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
        end
        band_valid = 1'b0; band_last = 1'b0;
        @(negedge clk);
        chk("acc_valid_t1", {63'd0, acc_valid_a}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("acc_valid_t2_a", {63'd0, acc_valid_a}, 64'd1);
        chk("acc_valid_t2_b", {63'd0, acc_valid_b}, 64'd1);
        chk("acc_value_a", acc_value_a, e32);
        chk("band_count_a", 64'(band_count_a), 64'(nb));
        chk("acc_of_a", {63'd0, acc_of_a}, 64'd0);
        chk("hsp_ref_a", 64'(hsp_ref_out_a), 64'(q_h[0]));
        chk("acc_value_b", 64'(acc_value_b), 64'(e16));
        chk("band_count_b", 64'(band_count_b), 64'(nb));
        chk("acc_of_b", {63'd0, acc_of_b}, {63'd0, eof16});
        chk("hsp_ref_b", 64'(hsp_ref_out_b), 64'(q_h[0]));
        repeat (wait_cyc) begin
            band_valid = 1'b1; vctp = 16'($urandom); vref = 16'($urandom);
            hsp_ref_in = 8'($urandom); band_last = 1'($urandom);
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_band_ready", {63'd0, band_ready_a}, 64'd0);
            chk("hold_acc_valid", {63'd0, acc_valid_a}, 64'd1);
            chk("hold_acc_value", acc_value_a, e32);
            chk("hold_count", 64'(band_count_a), 64'(nb));
            chk("hold_hsp", 64'(hsp_ref_out_a), 64'(q_h[0]));
        end
        band_valid = 1'b0; band_last = 1'b0; acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_band_ready", {63'd0, band_ready_a}, 64'd1);
        chk("post_hs_acc_valid", {63'd0, acc_valid_a}, 64'd0);
        chk("post_hs_acc_value", acc_value_a, 64'd0);
        chk("post_hs_count", 64'(band_count_a), 64'd0);
        chk("post_hs_of_b", {63'd0, acc_of_b}, 64'd0);
    endtask

    task automatic run_model_pixel(input int nb, input int gap_max, input int wait_cyc);
        longint unsigned s = model_sum(nb);
        logic of16 = (s > 64'h0000_0000_FFFF_FFFF);
        run_pixel(nb, gap_max, wait_cyc, s, of16 ? 32'hFFFF_FFFF : s[31:0], of16);
    endtask

    typedef struct {
        int          nb;
        logic [15:0] c[4];
        logic [15:0] r[4];
        logic [7:0]  h[4];
        logic [63:0] s32;
        logic [31:0] s16;
        logic        of16;
        int          wait_cyc;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3, '{16'd10, 16'd0, 16'd100, 16'd0}, '{16'd7, 16'd5, 16'd100, 16'd0},
                   '{8'd1, 8'd1, 8'd1, 8'd0}, 64'd34, 32'd34, 1'b0, 5};
        tbl[1] = '{2, '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'd0},
                   '{8'd2, 8'd2, 8'd0, 8'd0}, 64'h1_FFFC_0002, 32'hFFFF_FFFF, 1'b1, 0};
        tbl[2] = '{3, '{16'd1, 16'd7, 16'd0, 16'd0}, '{16'd2, 16'd3, 16'd0, 16'd0},
                   '{8'd5, 8'd9, 8'd9, 8'd0}, 64'd17, 32'd17, 1'b0, 0};
        tbl[3] = '{1, '{16'd200, 16'd0, 16'd0, 16'd0}, '{16'd50, 16'd0, 16'd0, 16'd0},
                   '{8'd7, 8'd0, 8'd0, 8'd0}, 64'd22500, 32'd22500, 1'b0, 0};
        tbl[4] = '{4, '{16'd0, 16'd1, 16'd5, 16'd300}, '{16'hFFFF, 16'd0, 16'd5, 16'd301},
                   '{8'd3, 8'd4, 8'd4, 8'd4}, 64'hFFFE_0003, 32'hFFFE_0003, 1'b0, 2};

        rst_n = 1'b0; clear = 1'b0; band_valid = 1'b0; band_last = 1'b0;
        acc_ready = 1'b0; vctp = '0; vref = '0; hsp_ref_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_acc_valid", {63'd0, acc_valid_a}, 64'd0);
        chk("rst_acc_value", acc_value_a, 64'd0);
        chk("rst_count", 64'(band_count_a), 64'd0);
        chk("rst_of", {63'd0, acc_of_a}, 64'd0);
        chk("rst_hsp", 64'(hsp_ref_out_a), 64'd0);
        chk("rst_band_ready", {63'd0, band_ready_a}, 64'd1);
        chk("rst_band_ready_b", {63'd0, band_ready_b}, 64'd1);

        // Table vectors (entry 2 then 3 is the reference-capture pair 5 -> 7).
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < tbl[v].nb; i++) begin
                q_c[i] = tbl[v].c[i]; q_r[i] = tbl[v].r[i]; q_h[i] = tbl[v].h[i];
            end
            run_pixel(tbl[v].nb, 0, tbl[v].wait_cyc, tbl[v].s32, tbl[v].s16, tbl[v].of16);
        end

        // clear after two bands drops the partial pixel; inputs during clear ignored.
        @(posedge clk); #1;
        band_valid = 1'b1; band_last = 1'b0; vctp = 16'd10; vref = 16'd2; hsp_ref_in = 8'd3;
        @(posedge clk); #1;
        vctp = 16'd6; vref = 16'd1;
        @(posedge clk); #1;
        clear = 1'b1; vctp = 16'd50; vref = 16'd0; band_last = 1'b1;
        @(negedge clk);
        chk("clear_band_ready", {63'd0, band_ready_a}, 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; band_valid = 1'b0; band_last = 1'b0;
        @(negedge clk);
        chk("clear_acc_value", acc_value_a, 64'd0);
        chk("clear_count", 64'(band_count_a), 64'd0);
        chk("clear_hsp", 64'(hsp_ref_out_a), 64'd0);
        chk("clear_band_ready_after", {63'd0, band_ready_a}, 64'd1);
        repeat (2) @(negedge clk);
        chk("clear_no_valid", {63'd0, acc_valid_a}, 64'd0);
        q_c[0] = 16'd4; q_r[0] = 16'd1; q_h[0] = 8'd11;
        run_pixel(1, 0, 0, 64'd9, 32'd9, 1'b0);

        // Reset in DRAIN aborts the pixel.
        @(posedge clk); #1;
        band_valid = 1'b1; band_last = 1'b1; vctp = 16'd9; vref = 16'd2; hsp_ref_in = 8'd6;
        @(posedge clk); #1;
        band_valid = 1'b0; band_last = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_drain_no_valid", {63'd0, acc_valid_a}, 64'd0);
        end
        chk("rst_drain_value", acc_value_a, 64'd0);
        q_c[0] = 16'd3; q_r[0] = 16'd3; q_h[0] = 8'd1;
        run_pixel(1, 0, 0, 64'd0, 32'd0, 1'b0);

        // Random pixels against the arithmetic model.
        for (int p = 0; p < 25; p++) begin
            int nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    q_c[i] = 16'($urandom); q_r[i] = 16'($urandom);
                end else begin
                    q_c[i] = 16'($urandom_range(0, 300)); q_r[i] = 16'($urandom_range(0, 300));
                end
                q_h[i] = 8'($urandom);
            end
            run_model_pixel(nb, 2, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
